// File: rtl/tmds_pkg.sv
// Shared constants and types for the DVI TMDS channel encoder.
package tmds_pkg;

  localparam int BIAS_W_DEF = 5;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  typedef logic [3:0] ones_t;

  function automatic logic [9:0] ctrl_token(input logic [1:0] ctrl);
    logic [9:0] tok;
    case (ctrl)
      2'b00:   tok = TOKEN_C00;
      2'b01:   tok = TOKEN_C01;
      2'b10:   tok = TOKEN_C10;
      default: tok = TOKEN_C11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_ones_count8.sv
// Combinational population count of one byte.
module tmds_ones_count8
  import tmds_pkg::*;
(
  input  logic [7:0] data,
  output ones_t      ones
);

  always_comb begin
    ones = '0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + ones_t'(data[i]);
    end
  end

endmodule

// File: rtl/tmds_encoder_dvi.sv
// DVI TMDS 8b/10b encoder for one colour channel, two-stage pipeline:
// stage 1 minimises transitions, stage 2 balances DC and muxes in control tokens.
module tmds_encoder_dvi
  import tmds_pkg::*;
#(
  parameter int BIAS_W = BIAS_W_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  input  logic       i_de,
  output logic [9:0] o_tmds
);

  ones_t      n1d;
  ones_t      n1q;
  ones_t      n0q;
  logic       use_xnor;
  logic [8:0] qm_next;
  logic [8:0] q_m;
  logic       de_s1;
  logic [1:0] ctrl_s1;
  logic [9:0] sym_next;

  logic signed [BIAS_W-1:0] bias;
  logic signed [BIAS_W-1:0] bias_next;
  logic signed [BIAS_W-1:0] diff;
  logic signed [BIAS_W-1:0] two_q8;
  logic signed [BIAS_W-1:0] two_nq8;

  tmds_ones_count8 u_count_in (
    .data (i_data),
    .ones (n1d)
  );

  always_comb begin
    use_xnor   = (n1d > 4'd4) || (n1d == 4'd4 && !i_data[0]);
    qm_next    = '0;
    qm_next[0] = i_data[0];
    for (int i = 1; i < 8; i++) begin
      qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ i_data[i]) : (qm_next[i-1] ^ i_data[i]);
    end
    qm_next[8] = ~use_xnor;
  end

  tmds_ones_count8 u_count_qm (
    .data (q_m[7:0]),
    .ones (n1q)
  );

  // Popcounts are zero-extended so the difference is a proper signed disparity.
  assign n0q     = 4'd8 - n1q;
  assign diff    = $signed(BIAS_W'(n1q)) - $signed(BIAS_W'(n0q));
  assign two_q8  = q_m[8] ? BIAS_W'(2) : '0;
  assign two_nq8 = q_m[8] ? '0 : BIAS_W'(2);

  always_comb begin
    sym_next  = TOKEN_C00;
    bias_next = '0;
    if (!de_s1) begin
      sym_next = ctrl_token(ctrl_s1);
    end else if (bias == '0 || n1q == n0q) begin
      sym_next  = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      bias_next = q_m[8] ? bias + diff : bias - diff;
    end else if ((!bias[BIAS_W-1] && n1q > n0q) || (bias[BIAS_W-1] && n0q > n1q)) begin
      sym_next  = {1'b1, q_m[8], ~q_m[7:0]};
      bias_next = bias + two_q8 - diff;
    end else begin
      sym_next  = {1'b0, q_m[8], q_m[7:0]};
      bias_next = bias - two_nq8 + diff;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_m     <= '0;
      de_s1   <= 1'b0;
      ctrl_s1 <= 2'b00;
      o_tmds  <= TOKEN_C00;
      bias    <= '0;
    end else begin
      q_m     <= qm_next;
      de_s1   <= i_de;
      ctrl_s1 <= i_ctrl;
      o_tmds  <= sym_next;
      bias    <= bias_next;
    end
  end

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Self-checking bench for tmds_encoder_dvi: directed scenarios plus a long
// randomized run compared against an arithmetic reference model.
module tb_tmds_encoder_dvi;

  localparam logic [9:0] T00 = 10'h354;
  localparam logic [9:0] T01 = 10'h0AB;
  localparam logic [9:0] T10 = 10'h154;
  localparam logic [9:0] T11 = 10'h2AB;

  logic       i_clk  = 1'b0;
  logic       i_rst  = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic [1:0] i_ctrl = 2'b00;
  logic       i_de   = 1'b0;
  logic [9:0] o_tmds;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0] sym;
    int         bias;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } exp_t;

  exp_t pend[$];
  exp_t cur;
  int   m_bias = 0;

  tmds_encoder_dvi dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .i_ctrl (i_ctrl),
    .i_de   (i_de),
    .o_tmds (o_tmds)
  );

  always #5 i_clk = ~i_clk;

  // q_m[i] is the parity of data[i:0]; the XNOR variant inverts odd positions.
  function automatic exp_t model(input logic de, input logic [7:0] d,
                                 input logic [1:0] c, inout int b);
    exp_t e;
    logic [9:0] toks[4];
    logic [7:0] qm;
    int n1d, n1q, n0q, q8, par;
    toks   = '{T00, T01, T10, T11};
    e.de   = de;
    e.data = d;
    e.ctrl = c;
    if (!de) begin
      b      = 0;
      e.sym  = toks[c];
      e.bias = 0;
      return e;
    end
    n1d = 0;
    for (int i = 0; i < 8; i++) n1d += int'(d[i]);
    q8 = ((n1d > 4) || (n1d == 4 && d[0] == 1'b0)) ? 0 : 1;
    par = 0;
    for (int i = 0; i < 8; i++) begin
      par   = par ^ int'(d[i]);
      qm[i] = ((par ^ ((q8 == 0) ? (i % 2) : 0)) != 0);
    end
    n1q = 0;
    for (int i = 0; i < 8; i++) n1q += int'(qm[i]);
    n0q = 8 - n1q;
    if (b == 0 || n1q == n0q) begin
      e.sym = (q8 == 1) ? {2'b01, qm} : {2'b10, ~qm};
      b     = b + ((q8 == 1) ? (n1q - n0q) : (n0q - n1q));
    end else if ((b > 0 && n1q > n0q) || (b < 0 && n0q > n1q)) begin
      e.sym = {1'b1, q8[0], ~qm};
      b     = b + 2 * q8 + (n0q - n1q);
    end else begin
      e.sym = {1'b0, q8[0], qm};
      b     = b - 2 * (1 - q8) + (n1q - n0q);
    end
    e.bias = b;
    return e;
  endfunction

  function automatic void decode(input logic [9:0] s, output logic de,
                                 output logic [7:0] d, output logic [1:0] c);
    logic [7:0] v;
    de = 1'b1;
    d  = 8'h00;
    c  = 2'b00;
    case (s)
      T00: begin de = 1'b0; c = 2'b00; end
      T01: begin de = 1'b0; c = 2'b01; end
      T10: begin de = 1'b0; c = 2'b10; end
      T11: begin de = 1'b0; c = 2'b11; end
      default: begin
        v    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = v[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
      end
    endcase
  endfunction

  // Advance one clock, keep the model's two-deep pipeline in step, sample 1 unit later.
  task automatic step();
    exp_t e;
    exp_t rst_e;
    rst_e = '{sym: T00, bias: 0, de: 1'b0, data: 8'h00, ctrl: 2'b00};
    @(posedge i_clk);
    if (i_rst || pend.size() == 0) begin
      m_bias = 0;
      pend.delete();
      cur = rst_e;
      pend.push_back(rst_e);
    end else begin
      e   = model(i_de, i_data, i_ctrl, m_bias);
      cur = pend.pop_front();
      pend.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_de = 1'b0; i_ctrl = 2'b00; i_data = 8'h00;
    step(); step();
    checks++;
    if (o_tmds !== T00) begin
      errors++; $display("FAIL reset_tmds got=%h want=%h", o_tmds, T00);
    end
    checks++;
    if (int'(dut.bias) != 0) begin
      errors++; $display("FAIL reset_bias got=%0d want=0", int'(dut.bias));
    end
    i_rst = 1'b0;
    step();
    checks++;
    if (o_tmds !== T00) begin
      errors++; $display("FAIL reset_release got=%h want=%h", o_tmds, T00);
    end
  endtask

  task automatic test_ctrl_tokens();
    logic [9:0] exp_tok[4];
    exp_tok = '{T00, T01, T10, T11};
    i_de = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) i_ctrl = 2'(i);
      step();
      if (i >= 1) begin
        checks++;
        if (o_tmds !== exp_tok[i-1]) begin
          errors++; $display("FAIL ctrl_token%0d got=%h want=%h", i - 1, o_tmds, exp_tok[i-1]);
        end
        checks++;
        if (int'(dut.bias) != 0) begin
          errors++; $display("FAIL ctrl_bias%0d got=%0d want=0", i - 1, int'(dut.bias));
        end
      end
    end
  endtask

  task automatic test_zero_data();
    logic [9:0] exp_sym[3];
    int         exp_b[3];
    exp_sym = '{10'h100, 10'h3FF, 10'h100};
    exp_b   = '{-8, 2, -6};
    i_de = 1'b1; i_data = 8'h00;
    step();
    for (int j = 0; j < 3; j++) begin
      step();
      checks++;
      if (o_tmds !== exp_sym[j]) begin
        errors++; $display("FAIL zero_sym%0d got=%h want=%h", j, o_tmds, exp_sym[j]);
      end
      checks++;
      if (int'(dut.bias) != exp_b[j]) begin
        errors++; $display("FAIL zero_bias%0d got=%0d want=%0d", j, int'(dut.bias), exp_b[j]);
      end
    end
  endtask

  task automatic test_ff_data();
    i_de = 1'b0; i_ctrl = 2'b00;
    step(); step();
    i_de = 1'b1; i_data = 8'hFF;
    step(); step();
    checks++;
    if (o_tmds !== 10'h200) begin
      errors++; $display("FAIL ff_sym got=%h want=200", o_tmds);
    end
    checks++;
    if (int'(dut.bias) != -8) begin
      errors++; $display("FAIL ff_bias got=%0d want=-8", int'(dut.bias));
    end
  endtask

  task automatic test_de_transition();
    i_de = 1'b1; i_data = 8'h00;
    step();
    i_de = 1'b0; i_ctrl = 2'b01;
    step();
    checks++;
    if (o_tmds !== 10'h3FF || int'(dut.bias) != 8) begin
      errors++; $display("FAIL de_video got=%h/%0d want=3ff/8", o_tmds, int'(dut.bias));
    end
    i_de = 1'b1; i_data = 8'h00;
    step();
    checks++;
    if (o_tmds !== T01 || int'(dut.bias) != 0) begin
      errors++; $display("FAIL de_blank got=%h/%0d want=%h/0", o_tmds, int'(dut.bias), T01);
    end
    step();
    checks++;
    if (o_tmds !== 10'h100 || int'(dut.bias) != -8) begin
      errors++; $display("FAIL de_restart got=%h/%0d want=100/-8", o_tmds, int'(dut.bias));
    end
  endtask

  task automatic test_mid_reset();
    logic [9:0] exp_sym[4];
    int         exp_b[4];
    exp_sym = '{T00, T00, 10'h100, 10'h3FF};
    exp_b   = '{0, 0, -8, 2};
    i_de = 1'b1; i_data = 8'h5A;
    step(); step();
    i_rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      i_rst  = 1'b0;
      i_data = 8'h00;
      checks++;
      if (o_tmds !== exp_sym[j] || int'(dut.bias) != exp_b[j]) begin
        errors++;
        $display("FAIL midrst%0d got=%h/%0d want=%h/%0d", j, o_tmds, int'(dut.bias), exp_sym[j], exp_b[j]);
      end
    end
  endtask

  task automatic test_random();
    int         burst;
    int         db;
    logic       dde;
    logic [7:0] dd;
    logic [1:0] dc;
    burst = 0;
    for (int n = 0; n < 20000; n++) begin
      if (burst == 0) begin
        i_de  = ~i_de;
        burst = i_de ? int'($urandom_range(1, 64)) : int'($urandom_range(1, 16));
      end
      burst--;
      i_data = 8'($urandom);
      i_ctrl = 2'($urandom_range(0, 3));
      i_rst  = ($urandom_range(0, 2999) == 0);
      step();
      db = int'(dut.bias);
      checks++;
      if (o_tmds !== cur.sym) begin
        errors++; $display("FAIL rnd_sym n=%0d got=%h want=%h", n, o_tmds, cur.sym);
      end
      checks++;
      if (db != cur.bias) begin
        errors++; $display("FAIL rnd_bias n=%0d got=%0d want=%0d", n, db, cur.bias);
      end
      checks++;
      if ((db % 2) != 0 || db > 10 || db < -10) begin
        errors++; $display("FAIL rnd_bias_range n=%0d got=%0d want=even in [-10,10]", n, db);
      end
      decode(o_tmds, dde, dd, dc);
      checks++;
      if (dde !== cur.de || (cur.de ? (dd !== cur.data) : (dc !== cur.ctrl))) begin
        errors++;
        $display("FAIL rnd_decode n=%0d got=%b/%h/%b want=%b/%h/%b", n, dde, dd, dc, cur.de, cur.data, cur.ctrl);
      end
    end
    i_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ctrl_tokens();
    test_zero_data();
    test_ff_data();
    test_de_transition();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
